// File: rtl/uart_debug_host.sv
// -----------------------------------------------------------------------------
// uart_debug_host
//
// Host-side master for the UART debug protocol. Sends opcodes, streams a
// program from a word ROM (LOAD) and captures the dump returned after a
// RUN or STEP into a byte buffer that local logic can read back.
//
// Optional feature macro: DEBUG_HOST_FRAME_CHECK_EN
//   defined   : o_frame_err flags a dump whose length cannot match the
//               data-memory + register + latch layout, or that overflowed.
//   undefined : o_frame_err is tied low and no check logic exists.
//
// Ports
//   i_clk, i_reset_n            clock, asynchronous active-low reset
//   i_cmd_valid, i_cmd_op       local command (0 LOAD,1 RUN,2 DEBUG,3 STEP,4 END)
//   o_cmd_ready                 high only while idle
//   o_prog_addr, i_prog_data    program ROM port (data one clock after address)
//   o_tx_data, o_tx_start       byte to UART TX with one-clock start pulse
//   i_tx_done                   UART TX finished the outstanding byte
//   i_rx_data, i_rx_done        byte from UART RX
//   i_dump_raddr, o_dump_rdata  dump buffer read port (one-clock latency)
//   o_dump_len                  bytes captured in the last dump
//   o_dump_valid                one-clock pulse when a dump completes
//   o_overflow                  dump exceeded the buffer depth
//   o_frame_err                 dump length inconsistent with the layout
// -----------------------------------------------------------------------------
module uart_debug_host #(
    parameter int NB_DATA      = 8,
    parameter int NB_PROG_ADDR = 8,
    parameter int NB_DUMP_ADDR = 9,
    parameter int TAIL_BYTES   = 173,
    parameter int IDLE_TIMEOUT = 4096
) (
    input  logic                    i_clk,
    input  logic                    i_reset_n,
    input  logic                    i_cmd_valid,
    input  logic [2:0]              i_cmd_op,
    output logic                    o_cmd_ready,
    output logic [NB_PROG_ADDR-1:0] o_prog_addr,
    input  logic [31:0]             i_prog_data,
    output logic [NB_DATA-1:0]      o_tx_data,
    output logic                    o_tx_start,
    input  logic                    i_tx_done,
    input  logic [NB_DATA-1:0]      i_rx_data,
    input  logic                    i_rx_done,
    input  logic [NB_DUMP_ADDR-1:0] i_dump_raddr,
    output logic [NB_DATA-1:0]      o_dump_rdata,
    output logic [NB_DUMP_ADDR:0]   o_dump_len,
    output logic                    o_dump_valid,
    output logic                    o_overflow,
    output logic                    o_frame_err
);

    localparam int DEPTH = 2 ** NB_DUMP_ADDR;
    localparam int LEN_W = NB_DUMP_ADDR + 1;
    localparam int CNT_W = $clog2(IDLE_TIMEOUT + 1);

    localparam logic [2:0] OP_LOAD = 3'd0;
    localparam logic [2:0] OP_RUN  = 3'd1;
    localparam logic [2:0] OP_STEP = 3'd3;
    localparam logic [2:0] OP_END  = 3'd4;

    localparam logic [NB_PROG_ADDR-1:0] LAST_ADDR = '1;
    // idle_cnt_q holds the number of quiet clocks since the last byte; the
    // return to IDLE is decided on the clock the count would reach the
    // timeout, so o_dump_valid lands exactly IDLE_TIMEOUT clocks after it.
    localparam logic [CNT_W-1:0] CNT_FIRE = CNT_W'(IDLE_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND_OP,
        S_WAIT_TX,
        S_FETCH,
        S_SEND_WORD,
        S_RX_DUMP
    } state_t;

    state_t                  state_q, state_d;
    logic [2:0]              op_q, op_d;
    logic                    in_word_q, in_word_d;     // opcode sent, now in program words
    logic [1:0]              byte_cnt_q, byte_cnt_d;   // byte of the current word, 0 = MSB
    logic [31:0]             word_q, word_d;
    logic                    last_word_q, last_word_d; // current word ends the LOAD stream
    logic [NB_PROG_ADDR-1:0] prog_addr_q, prog_addr_d;
    logic [NB_DATA-1:0]      tx_data_q, tx_data_d;
    logic [LEN_W-1:0]        dump_len_q, dump_len_d;
    logic                    overflow_q, overflow_d;
    logic                    dump_valid_q, dump_valid_d;
    logic [CNT_W-1:0]        idle_cnt_q, idle_cnt_d;
    logic                    got_byte_q, got_byte_d;   // timeout armed only after first byte
    logic                    mem_we;
    logic [NB_DATA-1:0]      rdata_q;
    logic [NB_DATA-1:0]      mem [DEPTH];

`ifdef DEBUG_HOST_FRAME_CHECK_EN
    localparam logic [LEN_W-1:0] TAIL_LEN = LEN_W'(TAIL_BYTES);
    logic                    frame_err_q, frame_err_d;
    logic [LEN_W-1:0]        body_len;
`endif

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        in_word_d    = in_word_q;
        byte_cnt_d   = byte_cnt_q;
        word_d       = word_q;
        last_word_d  = last_word_q;
        prog_addr_d  = prog_addr_q;
        tx_data_d    = tx_data_q;
        dump_len_d   = dump_len_q;
        overflow_d   = overflow_q;
        dump_valid_d = 1'b0;
        idle_cnt_d   = idle_cnt_q;
        got_byte_d   = got_byte_q;
        mem_we       = 1'b0;
        o_tx_start   = 1'b0;
`ifdef DEBUG_HOST_FRAME_CHECK_EN
        frame_err_d  = frame_err_q;
        body_len     = dump_len_q - TAIL_LEN;
`endif

        case (state_q)
            S_IDLE: begin
                // Ops 5..7 are swallowed: nothing changes.
                if (i_cmd_valid && (i_cmd_op <= OP_END)) begin
                    op_d        = i_cmd_op;
                    in_word_d   = 1'b0;
                    prog_addr_d = '0;
                    tx_data_d   = NB_DATA'(i_cmd_op);
                    state_d     = S_SEND_OP;
                end
            end

            S_SEND_OP: begin
                o_tx_start = 1'b1;
                state_d    = S_WAIT_TX;
            end

            S_SEND_WORD: begin
                o_tx_start = 1'b1;
                state_d    = S_WAIT_TX;
                // Advance the ROM address while the last byte is on the wire,
                // but never past the terminating word, so the next word's
                // data is already settled when FETCH samples it.
                if (byte_cnt_q == 2'd3) begin
                    last_word_d = (word_q == 32'hFFFF_FFFF) || (prog_addr_q == LAST_ADDR);
                    if (!last_word_d) begin
                        prog_addr_d = prog_addr_q + NB_PROG_ADDR'(1);
                    end
                end
            end

            S_WAIT_TX: begin
                if (i_tx_done) begin
                    if (in_word_q) begin
                        if (byte_cnt_q == 2'd3) begin
                            state_d = last_word_q ? S_IDLE : S_FETCH;
                        end else begin
                            byte_cnt_d = byte_cnt_q + 2'd1;
                            case (byte_cnt_q)
                                2'd0:    tx_data_d = NB_DATA'(word_q[23:16]);
                                2'd1:    tx_data_d = NB_DATA'(word_q[15:8]);
                                default: tx_data_d = NB_DATA'(word_q[7:0]);
                            endcase
                            state_d = S_SEND_WORD;
                        end
                    end else if (op_q == OP_LOAD) begin
                        state_d = S_FETCH;
                    end else if ((op_q == OP_RUN) || (op_q == OP_STEP)) begin
                        dump_len_d = '0;
                        overflow_d = 1'b0;
                        idle_cnt_d = '0;
                        got_byte_d = 1'b0;
`ifdef DEBUG_HOST_FRAME_CHECK_EN
                        frame_err_d = 1'b0;
`endif
                        state_d    = S_RX_DUMP;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end

            S_FETCH: begin
                word_d     = i_prog_data;
                tx_data_d  = NB_DATA'(i_prog_data[31:24]);
                byte_cnt_d = 2'd0;
                in_word_d  = 1'b1;
                state_d    = S_SEND_WORD;
            end

            S_RX_DUMP: begin
                // A byte always wins over a timeout landing on the same clock.
                if (i_rx_done) begin
                    if (!dump_len_q[NB_DUMP_ADDR]) begin
                        mem_we     = 1'b1;
                        dump_len_d = dump_len_q + LEN_W'(1);
                    end else begin
                        overflow_d = 1'b1;
                    end
                    idle_cnt_d = CNT_W'(1);
                    got_byte_d = 1'b1;
                end else if (got_byte_q) begin
                    if (idle_cnt_q == CNT_FIRE) begin
                        dump_valid_d = 1'b1;
                        state_d      = S_IDLE;
`ifdef DEBUG_HOST_FRAME_CHECK_EN
                        frame_err_d  = (dump_len_q < TAIL_LEN) || (body_len[1:0] != 2'b00)
                                       || overflow_q;
`endif
                    end else begin
                        idle_cnt_d = idle_cnt_q + CNT_W'(1);
                    end
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q      <= S_IDLE;
            op_q         <= '0;
            in_word_q    <= 1'b0;
            byte_cnt_q   <= '0;
            word_q       <= '0;
            last_word_q  <= 1'b0;
            prog_addr_q  <= '0;
            tx_data_q    <= '0;
            dump_len_q   <= '0;
            overflow_q   <= 1'b0;
            dump_valid_q <= 1'b0;
            idle_cnt_q   <= '0;
            got_byte_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            in_word_q    <= in_word_d;
            byte_cnt_q   <= byte_cnt_d;
            word_q       <= word_d;
            last_word_q  <= last_word_d;
            prog_addr_q  <= prog_addr_d;
            tx_data_q    <= tx_data_d;
            dump_len_q   <= dump_len_d;
            overflow_q   <= overflow_d;
            dump_valid_q <= dump_valid_d;
            idle_cnt_q   <= idle_cnt_d;
            got_byte_q   <= got_byte_d;
        end
    end

`ifdef DEBUG_HOST_FRAME_CHECK_EN
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            frame_err_q <= 1'b0;
        end else begin
            frame_err_q <= frame_err_d;
        end
    end
    assign o_frame_err = frame_err_q;
`else
    assign o_frame_err = 1'b0;
`endif

    // Dump buffer: plain RAM, no reset on contents.
    always_ff @(posedge i_clk) begin
        if (mem_we) begin
            mem[dump_len_q[NB_DUMP_ADDR-1:0]] <= i_rx_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= mem[i_dump_raddr];
        end
    end

    assign o_cmd_ready  = (state_q == S_IDLE);
    assign o_prog_addr  = prog_addr_q;
    assign o_tx_data    = tx_data_q;
    assign o_dump_rdata = rdata_q;
    assign o_dump_len   = dump_len_q;
    assign o_dump_valid = dump_valid_q;
    assign o_overflow   = overflow_q;

endmodule

// File: tb/tb_uart_debug_host.sv
// Testbench for uart_debug_host: UART TX responder, synchronous ROM model and
// a queue-based reference for the expected byte streams and dump results.
module tb_uart_debug_host;

    localparam int T     = 4096;
    localparam int DEPTH = 512;
    localparam int TAIL  = 173;

    logic        i_clk;
    logic        i_reset_n;
    logic        i_cmd_valid;
    logic [2:0]  i_cmd_op;
    logic        o_cmd_ready;
    logic [7:0]  o_prog_addr;
    logic [31:0] i_prog_data;
    logic [7:0]  o_tx_data;
    logic        o_tx_start;
    logic        i_tx_done;
    logic [7:0]  i_rx_data;
    logic        i_rx_done;
    logic [8:0]  i_dump_raddr;
    logic [7:0]  o_dump_rdata;
    logic [9:0]  o_dump_len;
    logic        o_dump_valid;
    logic        o_overflow;
    logic        o_frame_err;

    uart_debug_host dut (
        .i_clk        (i_clk),
        .i_reset_n    (i_reset_n),
        .i_cmd_valid  (i_cmd_valid),
        .i_cmd_op     (i_cmd_op),
        .o_cmd_ready  (o_cmd_ready),
        .o_prog_addr  (o_prog_addr),
        .i_prog_data  (i_prog_data),
        .o_tx_data    (o_tx_data),
        .o_tx_start   (o_tx_start),
        .i_tx_done    (i_tx_done),
        .i_rx_data    (i_rx_data),
        .i_rx_done    (i_rx_done),
        .i_dump_raddr (i_dump_raddr),
        .o_dump_rdata (o_dump_rdata),
        .o_dump_len   (o_dump_len),
        .o_dump_valid (o_dump_valid),
        .o_overflow   (o_overflow),
        .o_frame_err  (o_frame_err)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [7:0]  tx_log[$];
    int          gap_log[$];
    bit          busy;
    int          dly;
    bit          have_done;
    int          done_cyc;
    int          overlap;
    int          max_addr;
    logic [31:0] rom [256];

    initial forever begin
        @(posedge i_clk);
        cyc++;
    end

    // Synchronous ROM: data for the address seen at an edge appears just after it.
    initial begin
        logic [7:0] a;
        i_prog_data = '0;
        forever begin
            @(posedge i_clk);
            a = o_prog_addr;
            #1;
            i_prog_data = rom[a];
        end
    end

    // UART TX model: records each started byte and answers with i_tx_done.
    initial begin
        i_tx_done = 1'b0;
        busy      = 1'b0;
        have_done = 1'b0;
        overlap   = 0;
        dly       = 0;
        forever begin
            @(posedge i_clk);
            #1;
            i_tx_done = 1'b0;
            if (busy) begin
                if (dly == 0) begin
                    i_tx_done = 1'b1;
                    busy      = 1'b0;
                    have_done = 1'b1;
                    done_cyc  = cyc;
                end else begin
                    dly--;
                end
            end
            if (o_tx_start === 1'b1) begin
                if (busy) overlap++;
                if (have_done) gap_log.push_back(cyc - done_cyc);
                tx_log.push_back(o_tx_data);
                busy = 1'b1;
                dly  = $urandom_range(0, 3);
            end
        end
    end

    task automatic tick();
        @(posedge i_clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_cmd_ready"},  o_cmd_ready, 1);
        chk({tag, "_tx_start"},   o_tx_start, 0);
        chk({tag, "_tx_data"},    o_tx_data, 0);
        chk({tag, "_prog_addr"},  o_prog_addr, 0);
        chk({tag, "_dump_len"},   o_dump_len, 0);
        chk({tag, "_dump_valid"}, o_dump_valid, 0);
        chk({tag, "_overflow"},   o_overflow, 0);
        chk({tag, "_frame_err"},  o_frame_err, 0);
        chk({tag, "_rdata"},      o_dump_rdata, 0);
    endtask

    task automatic issue(input logic [2:0] op);
        tx_log.delete();
        gap_log.delete();
        have_done   = 1'b0;
        i_cmd_op    = op;
        i_cmd_valid = 1'b1;
        tick();
        i_cmd_valid = 1'b0;
    endtask

    task automatic wait_cmd_done(input string tag, input int budget);
        int n = 0;
        while (!(o_cmd_ready === 1'b1 && !busy) && n < budget) begin
            tick();
            n++;
            if (int'(o_prog_addr) > max_addr) max_addr = int'(o_prog_addr);
        end
        chk({tag, "_finished_in_time"}, n < budget, 1);
    endtask

    // Expected LOAD stream: opcode, then words MSB first until an all-ones
    // word or the last ROM address.
    task automatic run_load(input string tag, input int exp_max_addr);
        logic [7:0] exp_b[$];
        int         exp_gap;
        exp_b.push_back(8'h00);
        for (int i = 0; i < 256; i++) begin
            exp_b.push_back(rom[i][31:24]);
            exp_b.push_back(rom[i][23:16]);
            exp_b.push_back(rom[i][15:8]);
            exp_b.push_back(rom[i][7:0]);
            if (rom[i] == 32'hFFFF_FFFF) break;
        end
        max_addr = 0;
        issue(3'd0);
        chk({tag, "_start_after_accept"}, o_tx_start, 1);
        chk({tag, "_ready_low"}, o_cmd_ready, 0);
        wait_cmd_done(tag, 20000);
        chk({tag, "_byte_count"}, tx_log.size(), exp_b.size());
        for (int i = 0; i < exp_b.size() && i < tx_log.size(); i++)
            chk($sformatf("%s_byte%0d", tag, i), tx_log[i], exp_b[i]);
        chk({tag, "_gap_count"}, gap_log.size(), exp_b.size() - 1);
        for (int k = 1; k < exp_b.size() && k <= gap_log.size(); k++) begin
            exp_gap = ((k - 1) % 4 == 0) ? 2 : 1;
            chk($sformatf("%s_gap%0d", tag, k), gap_log[k-1], exp_gap);
        end
        chk({tag, "_no_overlap"}, overlap, 0);
        chk({tag, "_max_addr"}, max_addr, exp_max_addr);
    endtask

    function automatic logic exp_ferr(input int n);
        int len;
        len = (n < DEPTH) ? n : DEPTH;
`ifdef DEBUG_HOST_FRAME_CHECK_EN
        return (len < TAIL) || (((len - TAIL) % 4) != 0) || (n > DEPTH);
`else
        return 1'b0;
`endif
    endfunction

    // edge_at >= 0: after that byte, the next one arrives on the very clock
    // the idle timeout would otherwise end the dump.
    task automatic run_dump(input string tag, input logic [2:0] op, input int n,
                            input bit idx_pattern, input int edge_at);
        logic [7:0] data[$];
        logic [7:0] v;
        int         w, k, m;
        issue(op);
        chk({tag, "_start_after_accept"}, o_tx_start, 1);
        chk({tag, "_ready_low"}, o_cmd_ready, 0);
        w = 0;
        while (!(tx_log.size() == 1 && !busy) && w < 50) begin
            tick();
            w++;
        end
        chk({tag, "_opcode_sent"}, w < 50, 1);
        chk({tag, "_opcode"}, tx_log[0], {5'd0, op});
        tick();
        chk({tag, "_entry_len"}, o_dump_len, 0);
        chk({tag, "_entry_overflow"}, o_overflow, 0);
        chk({tag, "_entry_frame_err"}, o_frame_err, 0);
        chk({tag, "_entry_ready"}, o_cmd_ready, 0);
        for (int i = 0; i < n; i++) begin
            v = idx_pattern ? i[7:0] : 8'($urandom);
            data.push_back(v);
            i_rx_data = v;
            i_rx_done = 1'b1;
            tick();
            i_rx_done = 1'b0;
            if (i == edge_at + 1) chk({tag, "_no_end_on_collision"}, o_cmd_ready, 0);
            if (i == edge_at) repeat (T - 2) tick();
            else if (i != n - 1) repeat ($urandom_range(0, 2)) tick();
        end
        k = 1;
        while (o_dump_valid !== 1'b1 && k <= T + 4) begin
            tick();
            k++;
        end
        chk({tag, "_valid_latency"}, k, T);
        chk({tag, "_ready_with_valid"}, o_cmd_ready, 1);
        tick();
        chk({tag, "_valid_one_clock"}, o_dump_valid, 0);
        m = (n < DEPTH) ? n : DEPTH;
        chk({tag, "_len"}, o_dump_len, m);
        chk({tag, "_overflow"}, o_overflow, n > DEPTH);
        chk({tag, "_frame_err"}, o_frame_err, exp_ferr(n));
        for (int i = 0; i < m; i++) begin
            i_dump_raddr = i[8:0];
            tick();
            chk($sformatf("%s_rd%0d", tag, i), o_dump_rdata, data[i]);
        end
    endtask

    initial begin
        int term;
        i_reset_n    = 1'b0;
        i_cmd_valid  = 1'b0;
        i_cmd_op     = '0;
        i_rx_data    = '0;
        i_rx_done    = 1'b0;
        i_dump_raddr = '0;
        for (int i = 0; i < 256; i++) rom[i] = $urandom & 32'hFFFF_FFFE;
        repeat (3) tick();
        check_reset_outputs("reset");
        i_reset_n = 1'b1;
        repeat (10) tick();
        chk("idle_no_tx", tx_log.size(), 0);

        // Directed LOAD: word 2 is never addressed.
        rom[0] = 32'h8C01_0004;
        rom[1] = 32'hFFFF_FFFF;
        run_load("load_dir", 1);

        // Random program with terminator.
        for (int i = 0; i < 256; i++) rom[i] = $urandom & 32'h7FFF_FFFF;
        term = $urandom_range(2, 6);
        rom[term] = 32'hFFFF_FFFF;
        run_load("load_rand", term);

        // No terminator: stream ends after the last ROM address.
        for (int i = 0; i < 256; i++) rom[i] = $urandom & 32'hFFFF_FFFE;
        run_load("load_full", 255);
        chk("load_full_final_addr", o_prog_addr, 8'hFF);

        run_dump("step181", 3'd3, 181, 1'b1, -1);
        i_dump_raddr = 9'd180;
        tick();
        chk("step181_byte180", o_dump_rdata, 8'hB4);

        run_dump("run520", 3'd1, 520, 1'b0, -1);
        run_dump("step174", 3'd3, 174, 1'b0, -1);
        run_dump("run_coll", 3'd1, $urandom_range(20, 300), 1'b0, 7);

        // Reserved opcode is consumed silently.
        issue(3'd7);
        chk("op7_ready", o_cmd_ready, 1);
        repeat (5) tick();
        chk("op7_no_tx", tx_log.size(), 0);

        // DEBUG with a stray command while the byte is outstanding.
        issue(3'd2);
        chk("debug_start", o_tx_start, 1);
        tick();
        i_cmd_op    = 3'd0;
        i_cmd_valid = 1'b1;
        tick();
        i_cmd_valid = 1'b0;
        wait_cmd_done("debug", 50);
        repeat (6) tick();
        chk("debug_one_byte", tx_log.size(), 1);
        chk("debug_byte", tx_log[0], 8'h02);
        chk("debug_no_overlap", overlap, 0);

        // Reset in the middle of a dump.
        issue(3'd1);
        repeat (8) tick();
        for (int i = 0; i < 3; i++) begin
            i_rx_data = 8'hA5;
            i_rx_done = 1'b1;
            tick();
            i_rx_done = 1'b0;
        end
        chk("midreset_capturing", o_dump_len, 3);
        i_reset_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        tick();
        busy      = 1'b0;
        i_reset_n = 1'b1;
        repeat (2) tick();

        issue(3'd4);
        wait_cmd_done("end_op", 50);
        chk("end_op_count", tx_log.size(), 1);
        chk("end_op_byte", tx_log[0], 8'h04);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
